// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter:
// FSM state codes, grant codes and default geometry.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic GNT_IM = 1'b0;
  localparam logic GNT_DM = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side fetch/data ports plus the memory-side bus.
// slave = arbiter view, master = core/memory view.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              IM_REQ;
  logic [31:0]       IM_ADDR;
  logic              IM_ACK;
  logic [DATA_W-1:0] IM_DATA;

  logic              DM_REQ;
  logic              DM_WE;
  logic [31:0]       DM_ADDR;
  logic [DATA_W-1:0] DM_WR_DATA;
  logic              DM_ACK;
  logic [DATA_W-1:0] DM_RD_DATA;

  logic              MEM_EN;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA;

  modport slave (
    input  IM_REQ, IM_ADDR,
    input  DM_REQ, DM_WE, DM_ADDR, DM_WR_DATA,
    input  MEM_RDATA,
    output IM_ACK, IM_DATA,
    output DM_ACK, DM_RD_DATA,
    output MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA
  );

  modport master (
    output IM_REQ, IM_ADDR,
    output DM_REQ, DM_WE, DM_ADDR, DM_WR_DATA,
    output MEM_RDATA,
    input  IM_ACK, IM_DATA,
    input  DM_ACK, DM_RD_DATA,
    input  MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA
  );

endinterface

// File: rtl/mem_arbiter_prio.sv
// Grant select: data first, fetch forced after a run of
// MAX_DM_STREAK data grants while a fetch is pending.
module mem_arbiter_prio
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_DM_STREAK = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_im_req,
  input  logic i_dm_req,
  input  logic i_arb,
  output logic o_gnt
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  logic [SW-1:0] r_streak;
  logic          w_force_im;

  assign w_force_im = i_im_req && (r_streak == STREAK_MAX);
  assign o_gnt = (i_dm_req && !w_force_im) ? GNT_DM : GNT_IM;

  // only a fetch that is actually waiting keeps the run alive
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_streak <= '0;
    end else if (i_arb) begin
      if (!i_im_req || o_gnt == GNT_IM)
        r_streak <= '0;
      else if (r_streak != STREAK_MAX)
        r_streak <= r_streak + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between the
// fetch and data ports; one transaction in flight at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int MEM_LAT       = 1,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic CLK,
  input  logic Z_R,
  mem_arbiter_if.slave bus
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  logic [1:0]        r_state;
  logic              r_gnt;
  logic              r_we;
  logic [CW-1:0]     r_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_im_ack;
  logic              r_dm_ack;
  logic [DATA_W-1:0] r_im_data;
  logic [DATA_W-1:0] r_dm_data;

  logic              w_idle;
  logic              w_any;
  logic              w_gnt;
  logic [ADDR_W-1:0] w_addr;
  logic              w_unused;

  assign w_idle = (r_state == ST_IDLE);
  assign w_any  = bus.IM_REQ | bus.DM_REQ;

  // fetch uses byte addresses, data uses word addresses
  assign w_addr = (w_gnt == GNT_DM) ?
                  bus.DM_ADDR[ADDR_W-1:0] :
                  bus.IM_ADDR[ADDR_W+1:2];

  assign w_unused = ^{bus.IM_ADDR[31:ADDR_W+2],
                      bus.IM_ADDR[1:0],
                      bus.DM_ADDR[31:ADDR_W]};

  mem_arbiter_prio #(
    .MAX_DM_STREAK(MAX_DM_STREAK)
  ) u_prio (
    .i_clk   (CLK),
    .i_rst   (Z_R),
    .i_im_req(bus.IM_REQ),
    .i_dm_req(bus.DM_REQ),
    .i_arb   (w_idle),
    .o_gnt   (w_gnt)
  );

  always_ff @(posedge CLK or posedge Z_R) begin
    if (Z_R) begin
      r_state     <= ST_IDLE;
      r_gnt       <= GNT_IM;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_im_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_im_data   <= '0;
      r_dm_data   <= '0;
    end else begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      r_im_ack <= 1'b0;
      r_dm_ack <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt      <= w_gnt;
            r_we       <= (w_gnt == GNT_DM) && bus.DM_WE;
            r_mem_en   <= 1'b1;
            r_mem_we   <= (w_gnt == GNT_DM) && bus.DM_WE;
            r_mem_addr <= w_addr;
            if (w_gnt == GNT_DM)
              r_mem_wdata <= bus.DM_WR_DATA;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt <= '0;
          if (r_we) begin
            r_dm_ack <= 1'b1;
            r_state  <= ST_RESP;
          end else begin
            r_state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == CNT_LAST) begin
            if (r_gnt == GNT_DM) begin
              r_dm_data <= bus.MEM_RDATA;
              r_dm_ack  <= 1'b1;
            end else begin
              r_im_data <= bus.MEM_RDATA;
              r_im_ack  <= 1'b1;
            end
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.MEM_EN     = r_mem_en;
  assign bus.MEM_WE     = r_mem_we;
  assign bus.MEM_ADDR   = r_mem_addr;
  assign bus.MEM_WDATA  = r_mem_wdata;
  assign bus.IM_ACK     = r_im_ack;
  assign bus.IM_DATA    = r_im_data;
  assign bus.DM_ACK     = r_dm_ack;
  assign bus.DM_RD_DATA = r_dm_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two instances (MEM_LAT 1 and 3),
// behavioural memories, and a scoreboard of expected ACKs.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct {
    bit          dm;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  logic CLK;
  logic Z_R;

  mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) b1 ();
  mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) b3 ();

  mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1), .MAX_DM_STREAK(4))
    dut1 (.CLK(CLK), .Z_R(Z_R), .bus(b1.slave));
  mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3), .MAX_DM_STREAK(4))
    dut3 (.CLK(CLK), .Z_R(Z_R), .bus(b3.slave));

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   pend [2];
  bit   prev [2];
  logic [31:0] sh0 [1024];
  logic [31:0] sh1 [1024];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h2002_0005 : (32'hA500_0000 | 32'(i));
  endfunction

  // memory models
  logic [31:0] m1 [1024];
  logic [31:0] m3 [1024];
  logic [31:0] rd1, p0, p1, p2;

  always @(posedge CLK) begin
    if (Z_R) begin
      for (int i = 0; i < 1024; i++) m1[i] <= init_word(i);
    end else if (b1.MEM_EN) begin
      if (b1.MEM_WE) m1[b1.MEM_ADDR] <= b1.MEM_WDATA;
      else rd1 <= m1[b1.MEM_ADDR];
    end
  end
  assign b1.MEM_RDATA = rd1;

  always @(posedge CLK) begin
    if (Z_R) begin
      for (int i = 0; i < 1024; i++) m3[i] <= init_word(i);
    end else if (b3.MEM_EN && b3.MEM_WE) begin
      m3[b3.MEM_ADDR] <= b3.MEM_WDATA;
    end
    p0 <= m3[b3.MEM_ADDR];
    p1 <= p0;
    p2 <= p1;
  end
  assign b3.MEM_RDATA = p2;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int d, input logic ia, input logic da,
                     input logic en, input logic we,
                     input logic [31:0] idat, input logic [31:0] ddat);
    exp_t e;
    bit   have;
    if (we) chk($sformatf("we_needs_en%0d", d), en, 1);
    if (ia || da) begin
      chk($sformatf("ack_onehot%0d", d), ia & da, 0);
      chk($sformatf("ack_width%0d", d), prev[d], 0);
      chk($sformatf("en_per_ack%0d", d), pend[d], 1);
      pend[d] = 0;
      have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
      chk($sformatf("ack_expected%0d", d), have, 1);
      if (have) begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("ack_port%0d", d), da, e.dm);
        if (e.rd)
          chk($sformatf("rd_data%0d", d), e.dm ? ddat : idat, e.data);
      end
    end
    if (en) begin
      chk($sformatf("en_once%0d", d), pend[d], 0);
      pend[d]++;
    end
    prev[d] = ia | da;
  endtask

  always @(negedge CLK) begin
    if (Z_R) begin
      pend[0] = 0; pend[1] = 0;
      prev[0] = 0; prev[1] = 0;
    end else begin
      mon(0, b1.IM_ACK, b1.DM_ACK, b1.MEM_EN, b1.MEM_WE,
          b1.IM_DATA, b1.DM_RD_DATA);
      mon(1, b3.IM_ACK, b3.DM_ACK, b3.MEM_EN, b3.MEM_WE,
          b3.IM_DATA, b3.DM_RD_DATA);
    end
  end

  task automatic drive(input int d, input bit ir, input bit dr,
                       input bit we, input logic [31:0] ia,
                       input logic [31:0] da, input logic [31:0] wd);
    if (d == 0) begin
      b1.IM_REQ = ir; b1.DM_REQ = dr; b1.DM_WE = we;
      b1.IM_ADDR = ia; b1.DM_ADDR = da; b1.DM_WR_DATA = wd;
    end else begin
      b3.IM_REQ = ir; b3.DM_REQ = dr; b3.DM_WE = we;
      b3.IM_ADDR = ia; b3.DM_ADDR = da; b3.DM_WR_DATA = wd;
    end
  endtask

  task automatic push(input int d, input bit dm, input bit we,
                      input logic [9:0] ma, input logic [31:0] wd);
    exp_t e;
    e.dm = dm;
    e.rd = !we;
    e.data = we ? 32'h0 : ((d == 0) ? sh0[ma] : sh1[ma]);
    if (we && d == 0) sh0[ma] = wd;
    if (we && d == 1) sh1[ma] = wd;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic xact(input string tag, input int d, input bit dm,
                      input bit we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [9:0] ma,
                      input int lat);
    int  k;
    bit  ack;
    push(d, dm, we, ma, wd);
    drive(d, !dm, dm, we, addr, addr, wd);
    ack = 0;
    for (k = 1; k <= 20; k++) begin
      @(posedge CLK); #1;
      if (k == 1) begin
        if (d == 0)
          chk({tag, "_issue"}, {b1.MEM_EN, b1.MEM_WE, b1.MEM_ADDR},
              {1'b1, dm & we, ma});
        else
          chk({tag, "_issue"}, {b3.MEM_EN, b3.MEM_WE, b3.MEM_ADDR},
              {1'b1, dm & we, ma});
        if (we)
          chk({tag, "_wdata"}, (d == 0) ? b1.MEM_WDATA : b3.MEM_WDATA, wd);
      end
      if (d == 0) ack = dm ? b1.DM_ACK : b1.IM_ACK;
      else        ack = dm ? b3.DM_ACK : b3.IM_ACK;
      if (ack) break;
    end
    chk({tag, "_lat"}, k, lat);
    drive(d, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    @(posedge CLK); #1;
  endtask

  int nack;

  initial begin
    Z_R = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    drive(1, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    for (int i = 0; i < 1024; i++) begin
      sh0[i] = init_word(i);
      sh1[i] = init_word(i);
    end
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ctl1", {b1.IM_ACK, b1.DM_ACK, b1.MEM_EN, b1.MEM_WE,
                     b1.MEM_ADDR, b1.MEM_WDATA}, 64'h0);
    chk("rst_dat1", {b1.IM_DATA, b1.DM_RD_DATA}, 64'h0);
    chk("rst_ctl3", {b3.IM_ACK, b3.DM_ACK, b3.MEM_EN, b3.MEM_WE,
                     b3.MEM_ADDR, b3.MEM_WDATA}, 64'h0);
    chk("rst_dat3", {b3.IM_DATA, b3.DM_RD_DATA}, 64'h0);
    Z_R = 1'b0;
    @(posedge CLK); #1;

    xact("im_rd",    0, 0, 0, 32'h10,   32'h0,         10'd4,     3);
    xact("dm_wr",    0, 1, 1, 32'h7,    32'hDEAD_BEEF, 10'd7,     2);
    xact("dm_rd",    0, 1, 0, 32'h7,    32'h0,         10'd7,     3);
    xact("im_wrap",  0, 0, 0, 32'h1004, 32'h0,         10'd1,     3);
    xact("dm_rd3",   1, 1, 0, 32'h401,  32'h0,         10'd1,     5);
    xact("dm_wr3",   1, 1, 1, 32'h3FF,  32'h1234_5678, 10'h3FF,   2);
    xact("im_rd3",   1, 0, 0, 32'hFFC,  32'h0,         10'h3FF,   5);
    chk("dm_rd_hold", b1.DM_RD_DATA, 32'hDEAD_BEEF);

    // both requests held: DM x4, IM, DM x4, IM, DM
    for (int i = 0; i < 11; i++) begin
      if (i % 5 == 4) push(0, 0, 0, 10'h10, 32'h0);
      else            push(0, 1, 0, 10'h20, 32'h0);
    end
    drive(0, 1, 1, 0, 32'h40, 32'h20, 32'h0);
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK); #1;
      if (q0.size() == 0) break;
    end
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    chk("streak_drain", q0.size(), 0);
    repeat (3) @(posedge CLK);
    #1;

    // reset while the LAT=3 instance sits in WAIT
    drive(1, 0, 1, 0, 32'h0, 32'h5, 32'h0);
    repeat (3) @(posedge CLK);
    #1;
    chk("mid_wait", dut3.r_state, ST_WAIT);
    Z_R = 1'b1;
    #1;
    chk("rst_async", {b3.MEM_EN, b3.IM_ACK, b3.DM_ACK,
                      b1.MEM_EN, b1.IM_ACK, b1.DM_ACK}, 0);
    drive(1, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    Z_R = 1'b0;
    nack = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge CLK); #1;
      if (b3.IM_ACK || b3.DM_ACK) nack++;
    end
    chk("no_stale_ack", nack, 0);
    chk("idle_after_rst", dut3.r_state, ST_IDLE);
    for (int i = 0; i < 1024; i++) sh1[i] = init_word(i);
    xact("post_rst", 1, 0, 0, 32'h20, 32'h0, 10'd8, 5);

    repeat (2) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
